// File: rtl/key_edit_controller.sv
`default_nettype none
// ============================================================================
// Module      : key_edit_controller
// Description : Owns N_KEYS 10-digit BCD key registers, selects the slot shown
//               on the 12-digit seven-segment display, runs the digit-by-digit
//               edit session (cursor + typing flag) and blanks the display
//               while the RSA core is busy.
//               Optional feature macro: EDIT_TIMEOUT_EN (idle edit abort).
// Revision    : 1.0 - initial release
// ============================================================================
module key_edit_controller #(
    parameter int          N_KEYS         = 3,
    parameter logic [3:0]  MODE_CODE0     = 4'hB,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_center,
    input  logic                   busy_in,
    input  logic                   ld_valid,
    input  logic [1:0]             ld_slot,
    input  logic [39:0]            ld_bcd,
    output logic [N_KEYS*40-1:0]   keys_flat,
    output logic                   commit,
    output logic                   disp_en,
    output logic [3:0]             disp_mode,
    output logic [39:0]            disp_bcd,
    output logic                   typing,
    output logic [3:0]             cursor
);

    typedef enum logic [1:0] {
        S_VIEW = 2'd0,
        S_EDIT = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] C_LAST_SEL = 2'(N_KEYS - 1);
    localparam logic [2:0] C_NKEYS    = 3'(N_KEYS);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [39:0] shadow_q, shadow_d;
    logic [39:0] keys_q [N_KEYS];
    logic [39:0] keys_d [N_KEYS];
    logic        commit_q, commit_d;
    logic        disp_en_q, disp_en_d;
    logic [3:0]  disp_mode_q, disp_mode_d;
    logic [39:0] disp_bcd_q, disp_bcd_d;
    logic        typing_q, typing_d;

    logic [5:0]  w_nib_lsb;
    logic [3:0]  w_nib;
    logic [3:0]  w_nib_inc;
    logic [3:0]  w_nib_dec;
    logic        w_any_btn;

    assign w_nib_lsb = {cursor_q, 2'b00};
    assign w_nib     = shadow_q[w_nib_lsb +: 4];
    // Out-of-range nibbles (>9) snap to the wrap target of the direction pressed
    assign w_nib_inc = (w_nib >= 4'd9) ? 4'd0 : w_nib + 4'd1;
    assign w_nib_dec = (w_nib == 4'd0 || w_nib > 4'd9) ? 4'd9 : w_nib - 4'd1;
    assign w_any_btn = btn_up | btn_down | btn_left | btn_right | btn_center;

`ifdef EDIT_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state, key-write and registered-output computation
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cursor_d = cursor_q;
        shadow_d = shadow_q;
        keys_d   = keys_q;
        commit_d = 1'b0;
`ifdef EDIT_TIMEOUT_EN
        idle_d   = 32'd0;
`endif

        // Core load first so that a same-cycle commit to the same slot overrides it
        if (ld_valid && ({1'b0, ld_slot} < C_NKEYS)) begin
            keys_d[ld_slot] = ld_bcd;
        end

        case (state_q)
            S_VIEW: begin
                if (busy_in) begin
                    state_d = S_BUSY;
                end else if (btn_center) begin
                    shadow_d = keys_q[sel_q];
                    cursor_d = 4'd0;
                    state_d  = S_EDIT;
                end else if (btn_up || btn_down) begin
                    // Higher-priority button with no effect in VIEW; lower ones dropped
                    state_d = S_VIEW;
                end else if (btn_left) begin
                    sel_d = (sel_q == C_LAST_SEL) ? 2'd0 : sel_q + 2'd1;
                end else if (btn_right) begin
                    sel_d = (sel_q == 2'd0) ? C_LAST_SEL : sel_q - 2'd1;
                end
            end
            S_EDIT: begin
                if (btn_center) begin
                    keys_d[sel_q] = shadow_q;
                    commit_d      = 1'b1;
                    state_d       = S_VIEW;
                end else if (btn_up) begin
                    shadow_d[w_nib_lsb +: 4] = w_nib_inc;
                end else if (btn_down) begin
                    shadow_d[w_nib_lsb +: 4] = w_nib_dec;
                end else if (btn_left) begin
                    cursor_d = (cursor_q == 4'd9) ? 4'd0 : cursor_q + 4'd1;
                end else if (btn_right) begin
                    cursor_d = (cursor_q == 4'd0) ? 4'd9 : cursor_q - 4'd1;
                end
`ifdef EDIT_TIMEOUT_EN
                if (!w_any_btn) begin
                    if (idle_q + 32'd1 >= TIMEOUT_CYCLES) begin
                        // Abort: shadow simply goes stale, key untouched, no commit
                        state_d = S_VIEW;
                    end else begin
                        idle_d = idle_q + 32'd1;
                    end
                end
`endif
            end
            S_BUSY: begin
                if (!busy_in) begin
                    state_d = S_VIEW;
                end
            end
            default: begin
                state_d = S_VIEW;
            end
        endcase

        // Display outputs follow the next state so every event shows one cycle later
        typing_d    = (state_d == S_EDIT);
        disp_en_d   = (state_d != S_BUSY);
        disp_mode_d = MODE_CODE0 + {2'b00, sel_d};
        disp_bcd_d  = (state_d == S_EDIT) ? shadow_d : keys_d[sel_d];
    end

    // State, key and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_VIEW;
            sel_q       <= 2'd0;
            cursor_q    <= 4'd0;
            shadow_q    <= 40'd0;
            for (int s = 0; s < N_KEYS; s++) begin
                keys_q[s] <= 40'd0;
            end
            commit_q    <= 1'b0;
            disp_en_q   <= 1'b1;
            disp_mode_q <= MODE_CODE0;
            disp_bcd_q  <= 40'd0;
            typing_q    <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
            idle_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cursor_q    <= cursor_d;
            shadow_q    <= shadow_d;
            keys_q      <= keys_d;
            commit_q    <= commit_d;
            disp_en_q   <= disp_en_d;
            disp_mode_q <= disp_mode_d;
            disp_bcd_q  <= disp_bcd_d;
            typing_q    <= typing_d;
`ifdef EDIT_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    generate
        for (genvar s = 0; s < N_KEYS; s++) begin : g_flat
            assign keys_flat[40*s +: 40] = keys_q[s];
        end
    endgenerate

    assign commit    = commit_q;
    assign disp_en   = disp_en_q;
    assign disp_mode = disp_mode_q;
    assign disp_bcd  = disp_bcd_q;
    assign typing    = typing_q;
    assign cursor    = cursor_q;

endmodule
`default_nettype wire

// File: tb/tb_key_edit_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_edit_controller
// Description : Directed self-checking bench for key_edit_controller
//               (N_KEYS=3, MODE_CODE0=B, TIMEOUT_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_edit_controller;

    logic         clk;
    logic         rst;
    logic         btn_up, btn_down, btn_left, btn_right, btn_center;
    logic         busy_in;
    logic         ld_valid;
    logic [1:0]   ld_slot;
    logic [39:0]  ld_bcd;
    logic [119:0] keys_flat;
    logic         commit;
    logic         disp_en;
    logic [3:0]   disp_mode;
    logic [39:0]  disp_bcd;
    logic         typing;
    logic [3:0]   cursor;

    int n_checks = 0;
    int n_fail   = 0;

    key_edit_controller #(
        .N_KEYS         (3),
        .MODE_CODE0     (4'hB),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .busy_in    (busy_in),
        .ld_valid   (ld_valid),
        .ld_slot    (ld_slot),
        .ld_bcd     (ld_bcd),
        .keys_flat  (keys_flat),
        .commit     (commit),
        .disp_en    (disp_en),
        .disp_mode  (disp_mode),
        .disp_bcd   (disp_bcd),
        .typing     (typing),
        .cursor     (cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; pulses are dropped afterwards, busy_in is a level and is kept
    task automatic step();
        @(posedge clk);
        #1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_center = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] slot, input logic [39:0] val);
        ld_valid = 1'b1; ld_slot = slot; ld_bcd = val;
    endtask

    initial begin
        rst = 1'b1; busy_in = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_center = 1'b0; ld_valid = 1'b0; ld_slot = 2'd0; ld_bcd = 40'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_mode",   disp_mode, 4'hB);
        check("rst_bcd",    disp_bcd,  40'h0);
        check("rst_en",     disp_en,   1'b1);
        check("rst_typing", typing,    1'b0);
        check("rst_cursor", cursor,    4'd0);
        check("rst_commit", commit,    1'b0);
        check("rst_keys",   keys_flat, 120'h0);

        // Slot cycling with wrap
        btn_left = 1'b1; step();
        check("left1_mode", disp_mode, 4'hC);
        btn_left = 1'b1; step();
        check("left2_mode", disp_mode, 4'hD);
        btn_left = 1'b1; step();
        check("left3_mode", disp_mode, 4'hB);
        check("left3_bcd",  disp_bcd,  40'h0);
        check("left3_en",   disp_en,   1'b1);
        btn_right = 1'b1; step();
        check("right_wrap_mode", disp_mode, 4'hD);
        // left beats right in the same cycle
        btn_left = 1'b1; btn_right = 1'b1; step();
        check("prio_lr_mode", disp_mode, 4'hB);

        // Enter edit on slot 0, up x11 -> digit 0 becomes 1
        btn_center = 1'b1; step();
        check("edit_typing", typing, 1'b1);
        check("edit_cursor", cursor, 4'd0);
        for (int i = 0; i < 11; i++) begin
            btn_up = 1'b1; step();
        end
        check("up11_bcd", disp_bcd, 40'h1);
        btn_left = 1'b1; step();
        check("left_cursor", cursor, 4'd1);
        btn_down = 1'b1; step();
        check("down_wrap_bcd", disp_bcd, 40'h91);

        // Cursor wrap 0 -> 9, edit MSD, commit
        btn_right = 1'b1; step();
        check("right_cursor0", cursor, 4'd0);
        btn_right = 1'b1; step();
        check("right_cursor9", cursor, 4'd9);
        btn_up = 1'b1; step();
        check("msd_up_bcd", disp_bcd, 40'h1000000091);
        btn_center = 1'b1; step();
        check("commit_pulse",  commit,          1'b1);
        check("commit_typing", typing,          1'b0);
        check("commit_key0",   keys_flat[39:0], 40'h1000000091);
        check("commit_bcd",    disp_bcd,        40'h1000000091);
        step();
        check("commit_single", commit, 1'b0);

        // Busy beats a same-cycle button; loads still land; buttons ignored
        busy_in = 1'b1; btn_left = 1'b1; step();
        check("busy_en",   disp_en,   1'b0);
        check("busy_mode", disp_mode, 4'hB);
        load(2'd2, 40'h123); step();
        check("busy_ld_key2", keys_flat[119:80], 40'h123);
        load(2'd3, 40'h999); step();
        check("ld_bad_slot", keys_flat, {40'h123, 40'h0, 40'h1000000091});
        btn_center = 1'b1; step();
        check("busy_center_ign", typing, 1'b0);
        busy_in = 1'b0; step();
        check("unbusy_en",   disp_en,   1'b1);
        check("unbusy_mode", disp_mode, 4'hB);
        check("unbusy_bcd",  disp_bcd,  40'h1000000091);

        // Out-of-range nibbles: up on F -> 0, down on A -> 9
        load(2'd0, 40'hAF); step();
        check("ld_view_bcd", disp_bcd, 40'hAF);
        btn_center = 1'b1; step();
        btn_up = 1'b1; step();
        check("up_badnib", disp_bcd, 40'hA0);
        btn_left = 1'b1; step();
        btn_down = 1'b1; step();
        check("down_badnib", disp_bcd, 40'h90);
        // busy ignored in EDIT
        busy_in = 1'b1; step();
        check("edit_busy_ign", typing, 1'b1);
        busy_in = 1'b0;
        // center beats up
        btn_center = 1'b1; btn_up = 1'b1; step();
        check("prio_cu_commit", commit,          1'b1);
        check("prio_cu_key0",   keys_flat[39:0], 40'h90);

        // Load during edit leaves shadow alone; commit beats same-slot load
        load(2'd0, 40'h0); step();
        btn_center = 1'b1; step();
        for (int i = 0; i < 7; i++) begin
            btn_up = 1'b1; step();
        end
        load(2'd0, 40'h55); step();
        check("edit_ld_shadow", disp_bcd,        40'h7);
        check("edit_ld_key0",   keys_flat[39:0], 40'h55);
        btn_center = 1'b1; load(2'd0, 40'h5); step();
        check("commit_wins_key0", keys_flat[39:0], 40'h7);
        check("commit_wins_pulse", commit, 1'b1);

        // Reset mid-edit discards everything
        btn_center = 1'b1; step();
        btn_up = 1'b1; step();
        rst = 1'b1; step();
        rst = 1'b0;
        check("rst_edit_typing", typing,    1'b0);
        check("rst_edit_keys",   keys_flat, 120'h0);
        check("rst_edit_bcd",    disp_bcd,  40'h0);

`ifdef EDIT_TIMEOUT_EN
        // Idle edit aborts after TIMEOUT_CYCLES=16 idle cycles without commit
        btn_center = 1'b1; step();
        btn_up = 1'b1; step();
        check("to_shadow", disp_bcd, 40'h1);
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_no_commit", commit, 1'b0);
        end
        check("to_still_edit", typing, 1'b1);
        step();
        check("to_view",   typing,          1'b0);
        check("to_commit", commit,          1'b0);
        check("to_key0",   keys_flat[39:0], 40'h0);
        check("to_bcd",    disp_bcd,        40'h0);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
